seq_logic_alu: RTL and testbench

Sequential, parametrised successor to the team's combinational 4-bit logic unit. It performs one bitwise or shift/rotate operation per transaction on N-bit operands, with a valid/ready handshake on both input and output, registered results and status flags. Shifts execute serially, one bit position per cycle. It sits between the operand/opcode registers and the result display/register stage of the lab datapath.

---
 rtl/logic_alu_pkg.sv | 30 +++
 rtl/serial_shifter.sv | 71 +++++++
 rtl/seq_logic_alu.sv | 168 ++++++++++++++++
 tb/tb_seq_logic_alu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_alu_pkg.sv
// Shared types and helpers for the sequential logic ALU.
// Opcode and FSM state encodings plus opcode classification helpers.
package logic_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOT = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_ROL = 3'b110,
        OP_ROR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    function automatic logic is_shift(input op_e op);
        return op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR};
    endfunction

    function automatic logic is_left(input op_e op);
        return op inside {OP_SHL, OP_ROL};
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-step shifter/rotator with a down-counter; driven by the ALU FSM.
// Rotate fill is only built when LOGIC_ALU_ROTATE_EN is defined.
module serial_shifter
    import logic_alu_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  op_e           op,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] k,
    output logic [N-1:0]  next_value,
    output logic          next_carry,
    output logic          done
);

    logic [N-1:0]  value_q;
    logic [SW-1:0] count_q;
    logic          left_q;
    logic          fill;

`ifdef LOGIC_ALU_ROTATE_EN
    logic rot_q;
`endif

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_carry = left_q ? value_q[N-1] : value_q[0];
`ifdef LOGIC_ALU_ROTATE_EN
        fill = rot_q ? next_carry : 1'b0;
`else
        fill = 1'b0;
`endif
        next_value = left_q ? {value_q[N-2:0], fill} : {fill, value_q[N-1:1]};
    end

    // done flags the step that brings the counter to zero, so the caller
    // can capture next_value/next_carry on that same edge.
    assign done = (count_q == SW'(1));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
            left_q  <= 1'b0;
        end else if (load) begin
            value_q <= a;
            count_q <= k;
            left_q  <= is_left(op);
        end else if (step) begin
            value_q <= next_value;
            count_q <= count_q - SW'(1);
        end
    end

`ifdef LOGIC_ALU_ROTATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q <= 1'b0;
        end else if (load) begin
            rot_q <= op inside {OP_ROL, OP_ROR};
        end
    end
`endif

endmodule

// File: rtl/seq_logic_alu.sv
// Sequential N-bit logic/shift ALU with valid/ready handshakes and registered flags.
// Optional macro LOGIC_ALU_ROTATE_EN enables ROL/ROR; otherwise they are illegal opcodes.
module seq_logic_alu
    import logic_alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag_zero,
    output logic         flag_neg,
    output logic         flag_carry,
    output logic         flag_err
);

    localparam int SW = $clog2(N);

    state_e        state_q, state_d;
    op_e           op_in;
    logic [SW-1:0] k;
    logic [N-1:0]  logic_value;
    logic          logic_err;
    logic          load, step, cap_logic, cap_shift;
    logic [N-1:0]  sh_value;
    logic          sh_carry, sh_done;

    logic [N-1:0]  result_q;
    logic          zero_q, neg_q, carry_q;

    assign op_in = op_e'(op);
    assign k     = b[SW-1:0];

    // Shift amounts only use the low SW bits of b.
    logic unused_b_hi;
    assign unused_b_hi = ^b[N-1:SW];

    // Single-cycle result: logic ops, zero-distance shifts and illegal opcodes.
    always_comb begin
        logic_value = '0;
        logic_err   = 1'b0;
        case (op_in)
            OP_AND:         logic_value = a & b;
            OP_OR:          logic_value = a | b;
            OP_XOR:         logic_value = a ^ b;
            OP_NOT:         logic_value = ~a;
            OP_SHL, OP_SHR: logic_value = a;
`ifdef LOGIC_ALU_ROTATE_EN
            OP_ROL, OP_ROR: logic_value = a;
`else
            OP_ROL, OP_ROR: logic_err = 1'b1;
`endif
            default:        logic_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        cap_logic = 1'b0;
        cap_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift(op_in) && (k != '0) && !logic_err) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        cap_logic = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (sh_done) begin
                    cap_shift = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    serial_shifter #(
        .N  (N),
        .SW (SW)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .op         (op_in),
        .a          (a),
        .k          (k),
        .next_value (sh_value),
        .next_carry (sh_carry),
        .done       (sh_done)
    );

    // NOTE: the output registers are reset explicitly so an aborted transaction leaves nothing visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
        end else if (cap_logic) begin
            result_q <= logic_value;
            zero_q   <= (logic_value == '0);
            neg_q    <= logic_value[N-1];
            carry_q  <= 1'b0;
        end else if (cap_shift) begin
            result_q <= sh_value;
            zero_q   <= (sh_value == '0);
            neg_q    <= sh_value[N-1];
            carry_q  <= sh_carry;
        end
    end

`ifdef LOGIC_ALU_ROTATE_EN
    assign flag_err = 1'b0;
`else
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (cap_logic) begin
            err_q <= logic_err;
        end else if (cap_shift) begin
            err_q <= 1'b0;
        end
    end

    assign flag_err = err_q;
`endif

    // in_ready is gated by rst so the sender sees the block busy during reset.
    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == DONE);
    assign result     = result_q;
    assign flag_zero  = zero_q;
    assign flag_neg   = neg_q;
    assign flag_carry = carry_q;

endmodule

// File: tb/tb_seq_logic_alu.sv
// Self-checking bench for seq_logic_alu: directed cases plus randomized transactions
// compared against an arithmetic reference model (honours LOGIC_ALU_ROTATE_EN).
module tb_seq_logic_alu;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         flag_zero;
    logic         flag_neg;
    logic         flag_carry;
    logic         flag_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_logic_alu #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_neg   (flag_neg),
        .flag_carry (flag_carry),
        .flag_err   (flag_err)
    );

    typedef struct {
        int res;
        int zero;
        int neg;
        int carry;
        int err;
        int lat;
    } exp_t;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the operand values.
    function automatic exp_t model(input int o, input int av, input int bv);
        exp_t e;
        int   kk;
        int   r;
        int   c;
        int   rot_ok;
`ifdef LOGIC_ALU_ROTATE_EN
        rot_ok = 1;
`else
        rot_ok = 0;
`endif
        kk    = bv % N;
        r     = 0;
        c     = 0;
        e.err = 0;
        case (o)
            0: r = av & bv;
            1: r = av | bv;
            2: r = av ^ bv;
            3: r = ~av & MASK;
            4: begin
                r = (av << kk) & MASK;
                if (kk > 0) c = (av >> (N - kk)) & 1;
            end
            5: begin
                r = av >> kk;
                if (kk > 0) c = (av >> (kk - 1)) & 1;
            end
            6: begin
                if (rot_ok != 0) begin
                    r = ((av << kk) | (av >> (N - kk))) & MASK;
                    if (kk > 0) c = (av >> (N - kk)) & 1;
                end else begin
                    e.err = 1;
                end
            end
            default: begin
                if (rot_ok != 0) begin
                    r = ((av >> kk) | (av << (N - kk))) & MASK;
                    if (kk > 0) c = (av >> (kk - 1)) & 1;
                end else begin
                    e.err = 1;
                end
            end
        endcase
        e.res   = r;
        e.zero  = (r == 0) ? 1 : 0;
        e.neg   = (r >> (N - 1)) & 1;
        e.carry = c;
        e.lat   = (o >= 4 && kk > 0 && e.err == 0) ? kk + 1 : 1;
        return e;
    endfunction

    task automatic run_txn(input string name, input int o, input int av, input int bv, input int stall);
        exp_t e;
        int   lat;
        e = model(o, av, bv);
        out_ready = (stall == 0);
        @(negedge clk);
        check({name, "_in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        op       = o[2:0];
        a        = av[N-1:0];
        b        = bv[N-1:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom);
        a        = N'($urandom);
        b        = N'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({name, "_busy"}, int'(in_ready), 0);
            if (out_valid) break;
        end
        check({name, "_latency"}, lat, e.lat);
        check({name, "_result"}, int'(result), e.res);
        check({name, "_zero"}, int'(flag_zero), e.zero);
        check({name, "_neg"}, int'(flag_neg), e.neg);
        check({name, "_carry"}, int'(flag_carry), e.carry);
        check({name, "_err"}, int'(flag_err), e.err);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            op       = 3'($urandom);
            a        = N'($urandom);
            b        = N'($urandom);
            @(negedge clk);
            check({name, "_hold_result"}, int'(result), e.res);
            check({name, "_hold_valid"}, int'(out_valid), 1);
            check({name, "_hold_ready"}, int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_release_valid"}, int'(out_valid), 0);
        check({name, "_release_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        a         = '0;
        b         = '0;
        #1;
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_result", int'(result), 0);
        check("reset_flags", int'({flag_zero, flag_neg, flag_carry, flag_err}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_in_ready", int'(in_ready), 1);

        run_txn("and", 0, 4'b1100, 4'b1010, 0);
        run_txn("shl", 4, 4'b0011, 4'b0010, 0);
        run_txn("shr", 5, 4'b0101, 4'b0011, 0);
        run_txn("ror", 7, 4'b0001, 4'b0001, 0);
        run_txn("rol_k0", 6, 4'b1011, 4'b0100, 0);
        run_txn("xor_bp", 2, 4'b1111, 4'b0101, 5);

        // Abort a shift with reset while the previous result 1010 is still visible.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd4;
        a        = 4'b0001;
        b        = 4'b0011;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_result", int'(result), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_flags", int'({flag_zero, flag_neg, flag_carry, flag_err}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_valid", int'(out_valid), 0);
        end
        rst = 1'b0;
        #1;
        check("abort_release_ready", int'(in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_idle_valid", int'(out_valid), 0);
        end
        run_txn("after_abort", 4, 4'b0001, 4'b0011, 0);

        for (int i = 0; i < 40; i++) begin
            run_txn("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
                    int'($urandom_range(0, MASK)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
